// File: rtl/poly_root_unit.sv
// rtl/poly_root_unit.sv - iterative y = ka*a + kb*root(b), floor square or cube root.
// Optional PRU_SATURATE_EN: clamp y_bo to all-ones on overflow and report it on sat_o.
module poly_root_unit #(
  parameter int WIDTH = 8,
  parameter int KW    = 4,
  parameter int OUT_W = WIDTH + KW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] a_bi,
  input  logic [WIDTH-1:0] b_bi,
  input  logic [KW-1:0]    ka_bi,
  input  logic [KW-1:0]    kb_bi,
  output logic             busy_o,
  output logic             done_o,
  output logic [OUT_W-1:0] y_bo
`ifdef PRU_SATURATE_EN
  ,
  output logic             sat_o
`endif
);

  localparam int PW = WIDTH + 2;
  localparam int RW = WIDTH / 2 + 1;
  localparam int AW = OUT_W + 1;
  localparam int CW = $clog2(KW + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_MUL_A, S_ROOT, S_MUL_B, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic             mode_q, mode_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [KW-1:0]    kb_q, kb_d;
  logic [KW-1:0]    k_q, k_d;
  logic [AW-1:0]    m_q, m_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [RW-1:0]    r_q, r_d;
  logic [PW-1:0]    p_q, p_d;
  logic [PW-1:0]    s_q, s_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [OUT_W-1:0] y_q, y_d;
`ifdef PRU_SATURATE_EN
  logic             sat_q, sat_d;
`endif

  // s tracks (r+1)^2; p tracks (r+1)^n. Both step without multipliers.
  logic [PW-1:0] r_ext, rp1, rp1_x3, s_x3, sq_step, cube_step;
  logic          p_le_b, mul_last;

  always_comb begin
    r_ext     = PW'(r_q);
    rp1       = r_ext + PW'(1);
    rp1_x3    = {rp1[PW-2:0], 1'b0} + rp1;
    s_x3      = {s_q[PW-2:0], 1'b0} + s_q;
    sq_step   = {r_ext[PW-2:0], 1'b0} + PW'(3);
    cube_step = s_x3 + rp1_x3 + PW'(1);
    p_le_b    = (p_q <= {2'b00, b_q});
    mul_last  = (cnt_q == CW'(KW - 1));
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    b_d     = b_q;
    kb_d    = kb_q;
    k_d     = k_q;
    m_d     = m_q;
    acc_d   = acc_q;
    r_d     = r_q;
    p_d     = p_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
`ifdef PRU_SATURATE_EN
    sat_d   = sat_q;
`endif
    case (state_q)
      S_IDLE: begin
        // Operands are captured on the start edge so later input changes are harmless.
        if (start_i) begin
          state_d = S_LOAD;
          mode_d  = mode_i;
          b_d     = b_bi;
          kb_d    = kb_bi;
          m_d     = AW'(a_bi);
          k_d     = ka_bi;
        end
      end
      S_LOAD: begin
        acc_d   = '0;
        r_d     = '0;
        p_d     = PW'(1);
        s_d     = PW'(1);
        cnt_d   = '0;
        state_d = S_MUL_A;
      end
      S_MUL_A, S_MUL_B: begin
        acc_d = acc_q + (k_q[0] ? m_q : '0);
        m_d   = m_q << 1;
        k_d   = k_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (mul_last) begin
          cnt_d = '0;
          if (state_q == S_MUL_A) begin
            state_d = S_ROOT;
          end else begin
            state_d = S_DONE;
`ifdef PRU_SATURATE_EN
            sat_d = acc_d[OUT_W];
            y_d   = acc_d[OUT_W] ? {OUT_W{1'b1}} : acc_d[OUT_W-1:0];
`else
            y_d   = acc_d[OUT_W-1:0];
`endif
          end
        end
      end
      S_ROOT: begin
        if (p_le_b) begin
          r_d = r_q + RW'(1);
          s_d = s_q + sq_step;
          p_d = mode_q ? (p_q + cube_step) : (p_q + sq_step);
        end else begin
          m_d     = AW'(r_q);
          k_d     = kb_q;
          state_d = S_MUL_B;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      b_q     <= '0;
      kb_q    <= '0;
      k_q     <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      r_q     <= '0;
      p_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
`ifdef PRU_SATURATE_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      b_q     <= b_d;
      kb_q    <= kb_d;
      k_q     <= k_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      r_q     <= r_d;
      p_q     <= p_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
`ifdef PRU_SATURATE_EN
      sat_q   <= sat_d;
`endif
    end
  end

  assign busy_o = (state_q != S_IDLE);
  assign done_o = (state_q == S_DONE);
  assign y_bo   = y_q;
`ifdef PRU_SATURATE_EN
  assign sat_o  = sat_q;
`endif

endmodule

// File: tb/tb_poly_root_unit.sv
// tb/tb_poly_root_unit.sv - directed bench for poly_root_unit (default and OUT_W=11 instances).
// Honours PRU_SATURATE_EN for the sat_o port and the clamped narrow result.
module tb_poly_root_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i, mode_i;
  logic [7:0]  a_i, b_i;
  logic [3:0]  ka_i, kb_i;
  logic        busy, done, busy11, done11;
  logic [12:0] y;
  logic [10:0] y11;
`ifdef PRU_SATURATE_EN
  logic        sat, sat11;
`endif

  int errors = 0;
  int checks = 0;
  int lat;
  int dn;
  int first_lat;
  logic [12:0] y_seen;

  always #5 clk = ~clk;

  poly_root_unit u_dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_i), .mode_i(mode_i),
    .a_bi(a_i), .b_bi(b_i), .ka_bi(ka_i), .kb_bi(kb_i),
    .busy_o(busy), .done_o(done), .y_bo(y)
`ifdef PRU_SATURATE_EN
    , .sat_o(sat)
`endif
  );

  poly_root_unit #(.WIDTH(8), .KW(4), .OUT_W(11)) u_dut11 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_i), .mode_i(mode_i),
    .a_bi(a_i), .b_bi(b_i), .ka_bi(ka_i), .kb_bi(kb_i),
    .busy_o(busy11), .done_o(done11), .y_bo(y11)
`ifdef PRU_SATURATE_EN
    , .sat_o(sat11)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Latency counts edges from the start-sampling edge to the edge closing the done_o cycle.
  task automatic run_op(input logic m, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] ka, input logic [3:0] kb, output int l);
    @(negedge clk);
    mode_i = m; a_i = a; b_i = b; ka_i = ka; kb_i = kb; start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    l = 1;
    while (done !== 1'b1 && l < 200) begin
      @(posedge clk);
      @(negedge clk);
      l++;
    end
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; mode_i = 1'b0;
    a_i = '0; b_i = '0; ka_i = '0; kb_i = '0;
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_y", 32'(y), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int n = 1; n <= 7; n++) begin
      run_op(1'b1, 8'(n), 8'(n), 4'd3, 4'd2, lat);
      check($sformatf("cube_sweep_y_%0d", n), 32'(y), 32'(3 * n + 2));
      check($sformatf("cube_sweep_lat_%0d", n), 32'(lat), 32'd12);
    end

    run_op(1'b1, 8'd32, 8'd128, 4'd3, 4'd2, lat);
    check("cube_32_128_y", 32'(y), 32'd106);
    check("cube_32_128_lat", 32'(lat), 32'd16);
    run_op(1'b1, 8'd48, 8'd192, 4'd3, 4'd2, lat);
    check("cube_48_192_y", 32'(y), 32'd154);
    check("cube_48_192_lat", 32'(lat), 32'd16);
    @(posedge clk);
    @(negedge clk);
    check("done_single_cycle", 32'(done), 32'd0);
    check("idle_after_done", 32'(busy), 32'd0);
    check("y_holds", 32'(y), 32'd154);

    run_op(1'b0, 8'd10, 8'd200, 4'd1, 4'd5, lat);
    check("sqrt_10_200_y", 32'(y), 32'd80);
    check("sqrt_10_200_lat", 32'(lat), 32'd25);
    run_op(1'b0, 8'd0, 8'd0, 4'd1, 4'd5, lat);
    check("zero_y", 32'(y), 32'd0);
    check("zero_lat", 32'(lat), 32'd11);

    run_op(1'b1, 8'd255, 8'd255, 4'd15, 4'd15, lat);
    check("max_cube_y", 32'(y), 32'd3915);
    check("max_cube_lat", 32'(lat), 32'd17);
    run_op(1'b0, 8'd255, 8'd255, 4'd15, 4'd15, lat);
    check("max_sqrt_y", 32'(y), 32'd4050);
    check("max_sqrt_lat", 32'(lat), 32'd26);
    check("narrow_done", 32'(done11), 32'd1);
`ifdef PRU_SATURATE_EN
    check("narrow_sat_y", 32'(y11), 32'd2047);
    check("narrow_sat_flag", 32'(sat11), 32'd1);
    check("wide_sat_flag", 32'(sat), 32'd0);
`else
    check("narrow_wrap_y", 32'(y11), 32'd2002);
`endif

    // Held start plus a mid-ROOT start with altered operands must not disturb the run.
    @(negedge clk);
    mode_i = 1'b1; a_i = 8'd5; b_i = 8'd100; ka_i = 4'd3; kb_i = 4'd2; start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_i = 8'd99; b_i = 8'd3; ka_i = 4'd0; kb_i = 4'd0; mode_i = 1'b0;
    dn = 0; first_lat = 0; y_seen = '0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 2) start_i = 1'b0;
      if (k == 6) begin start_i = 1'b1; a_i = 8'd77; end
      if (k == 7) start_i = 1'b0;
      if (done === 1'b1) begin
        dn++;
        if (dn == 1) begin
          first_lat = k + 1;
          y_seen = y;
        end
      end
    end
    check("ignore_start_done_count", 32'(dn), 32'd1);
    check("ignore_start_lat", 32'(first_lat), 32'd15);
    check("ignore_start_y", 32'(y_seen), 32'd23);

    // Reset lands while MUL_B is running (sqrt 255 puts MUL_B after edges 21..24).
    @(negedge clk);
    mode_i = 1'b0; a_i = 8'd255; b_i = 8'd255; ka_i = 4'd15; kb_i = 4'd15; start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    repeat (22) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("busy_before_reset", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_busy", 32'(busy), 32'd0);
    check("async_reset_done", 32'(done), 32'd0);
    check("async_reset_y", 32'(y), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b1, 8'd48, 8'd192, 4'd3, 4'd2, lat);
    check("post_reset_y", 32'(y), 32'd154);
    check("post_reset_lat", 32'(lat), 32'd16);
    check("post_reset_narrow_y", 32'(y11), 32'd154);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/poly_root_unit.md
Name: poly_root_unit

Overview:
Iterative arithmetic unit computing y = ka*a + kb*root(b), where root is the floor square root or floor cube root, selected per operation.
It is the parametrised successor of the fixed 3a + 2*cbrt(b) unit: generic operand width, runtime coefficients and a runtime root mode.
It uses shift-add multiplication and incremental power tracking (adders only, no multiplier or divider operators).
It sits under a start/busy handshake in the lab datapath.

Parameters:
WIDTH, 8, width of operands a and b
KW, 4, width of runtime coefficients ka and kb
OUT_W, WIDTH+KW+1, width of result y

Ports:
clk_i  input  1  system clock, all state on rising edge
rst_ni  input  1  asynchronous active-low reset
start_i  input  1  request; sampled only in IDLE
mode_i  input  1  0 = square root, 1 = cube root; latched at start
a_bi  input  WIDTH  operand a; latched at start
b_bi  input  WIDTH  operand b; latched at start
ka_bi  input  KW  coefficient for a; latched at start
kb_bi  input  KW  coefficient for root(b); latched at start
busy_o  output  1  high whenever state != IDLE
done_o  output  1  one-cycle pulse when y_bo updates
y_bo  output  OUT_W  result; holds last value until next done

Behaviour:
- Reset: rst_ni low immediately forces IDLE, busy_o=0, done_o=0, y_bo=0, all internal registers 0. This applies at any time, including mid-operation; the aborted operation produces no done_o.
- States and transitions:
  - IDLE: start_i=1 -> LOAD.
  - LOAD (1 cycle): latch a, b, ka, kb, mode; clear accumulator; root r=0; next power p=1; pow increments initialised.
  - MUL_A (KW cycles): LSB-first shift-add; acc += a<<i when ka[i]=1.
  - ROOT (r_final+1 cycles): each cycle compare p = (r+1)^n against b.
    - If p <= b: r <= r+1; update p by incremental identities. Square: (r+2)^2 = p + 2r + 3. Cube: keep a square term s=(r+1)^2 and update p += 3s + 3(r+1) + 1 with matching s update.
    - Else -> MUL_B.
  - MUL_B (KW cycles): acc += r<<i when kb[i]=1.
  - DONE (1 cycle): y_bo <= acc[OUT_W-1:0]; done_o=1; -> IDLE.
- Latency from start sample edge to done_o: 2*KW + r_final + 3 cycles. busy_o is high from the cycle after start sample through DONE inclusive.
- Internal power/compare registers are WIDTH+2 bits so that p never wraps before the compare. r is at most WIDTH/2+1 bits.
- Overflow: acc is OUT_W+1 bits internally. By default y_bo takes the low OUT_W bits (modulo). With the defaults, overflow cannot occur.
- start_i while busy_o=1, including during DONE, is ignored; inputs are not re-latched.
- Input changes after LOAD have no effect on the running operation.
- b=0: ROOT lasts 1 cycle, r=0. ka=0 or kb=0: the corresponding MUL stage still takes KW cycles (fixed-length stages).
- done_o and busy_o are never both low while an operation is in flight. done_o coincides with the last busy_o cycle.

Optional Feature:
Macro PRU_SATURATE_EN.
- Defined: if the full sum is >= 2^OUT_W, y_bo = 2^OUT_W-1 and sat_o (extra 1-bit output, reset 0, updated at DONE) = 1; otherwise sat_o = 0.
- Undefined: the sat_o port is absent and y_bo wraps modulo 2^OUT_W.

Test Plan:
- Defaults, mode=1, ka=3, kb=2. Sweep a=b=n for n=1..7 -> y=3n+2. (32,128) -> 106. (48,192) -> 154, done_o exactly 16 cycles after start sample.
- mode=0, ka=1, kb=5, a=10, b=200 -> root 14, y=80, latency 25 cycles. a=0, b=0 -> y=0, latency 11 cycles.
- Maximums: a=b=255, ka=kb=15. mode=1 -> y=3915; mode=0 -> y=4050. No wrap at OUT_W=13.
- Pulse start_i for 3 consecutive cycles, and again mid-ROOT, with changed a_bi -> exactly one done_o and the result for the originally latched operands. A start asserted in the cycle after DONE is accepted.
- Assert rst_ni=0 mid-MUL_B -> busy_o, done_o and y_bo are 0 immediately (asynchronously). A new operation after release completes correctly.
- OUT_W=11, mode=0, a=b=255, ka=kb=15 -> with PRU_SATURATE_EN: y=2047, sat_o=1. Without it: y=2002.
